// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, PC+4, redirect handling and the
// IF/ID pipeline register that feeds Decode and the immediate generator.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [24:0] ImmInstD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc_plus4_d_r;
    logic        valid_d_r;

    // Sequential fetch address, wrapping modulo 2^32
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
    end

    // Next PC: a redirect wins over a fetch stall; target low bits are forced to zero
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (PCSrcE) begin
            pc_next_s = {PCTargetE[31:2], 2'b00};
        end else if (StallF) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID register: reset and flush load a bubble, stall holds, else capture fetch
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end else if (StallD) begin
            instr_d_r    <= instr_d_r;
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= valid_d_r;
        end else begin
            instr_d_r    <= InstrF;
            pc_d_r       <= pc_r;
            pc_plus4_d_r <= pc_plus4_s;
            valid_d_r    <= 1'b1;
        end
    end

    assign PCF      = pc_r;
    assign InstrD   = instr_d_r;
    assign ImmInstD = instr_d_r[31:7];
    assign PCD      = pc_d_r;
    assign PCPlus4D = pc_plus4_d_r;
    assign ValidD   = valid_d_r;

endmodule
